seg7_reader: RTL

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_reader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seg7_reader.sv
// seg7_reader: assembles two active-low 7-segment digits into one byte.
// The first accepted digit is the high nibble and the second the low nibble.
// The finished word is held on WORD/WORD_VALID until the consumer takes it.
// A pattern that is not a hex digit raises a one-cycle ERR pulse and drops any
// partial word. ERR_COUNT counts ERR pulses and saturates at 255.
// Build option: define SEG7_READER_TIMEOUT_EN to add an inter-digit timeout.
// With it, waiting TIMEOUT_CYCLES idle cycles for the low digit raises ERR
// with ERR_TYPE=10 and returns to EMPTY.
module seg7_reader #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] SEG,
    input  logic       SEG_VALID,
    output logic       SEG_READY,
    output logic [7:0] WORD,
    output logic       WORD_VALID,
    input  logic       WORD_READY,
    output logic       ERR,
    output logic [1:0] ERR_TYPE,
    output logic [7:0] ERR_COUNT
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HALF  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PATTERN = 2'b01;
`ifdef SEG7_READER_TIMEOUT_EN
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
`endif

    // A timeout of zero cycles has no meaning, so reject it when the design is elaborated.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("seg7_reader: TIMEOUT_CYCLES must be at least 1");
    end

    // Maps an active-low segment pattern to {recognised, nibble}.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0011000: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b0001110: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    // Adds one to the error counter, but stops at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0] state;
    logic [3:0] hi_nib;
    logic [4:0] dec;
    logic       dec_ok;
    logic [3:0] dec_nib;
    logic       unused_seg7;

`ifdef SEG7_READER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] idle_cnt;
`endif

    assign dec         = seg_decode(SEG[6:0]);
    assign dec_ok      = dec[4];
    assign dec_nib     = dec[3:0];
    assign unused_seg7 = SEG[7];

    // The block can take a digit whenever no finished word is waiting.
    assign SEG_READY = (state != FULL);

    // Handshake FSM, word assembly, error pulse and error counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= EMPTY;
            hi_nib     <= 4'h0;
            WORD       <= 8'h00;
            WORD_VALID <= 1'b0;
            ERR        <= 1'b0;
            ERR_TYPE   <= ERR_NONE;
            ERR_COUNT  <= 8'h00;
`ifdef SEG7_READER_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
        end else begin
            ERR      <= 1'b0;
            ERR_TYPE <= ERR_NONE;
            case (state)
                EMPTY: begin
                    if (SEG_VALID) begin
                        if (dec_ok) begin
                            hi_nib <= dec_nib;
                            state  <= HALF;
`ifdef SEG7_READER_TIMEOUT_EN
                            idle_cnt <= '0;
`endif
                        end else begin
                            ERR       <= 1'b1;
                            ERR_TYPE  <= ERR_PATTERN;
                            ERR_COUNT <= sat_inc(ERR_COUNT);
                        end
                    end
                end
                HALF: begin
                    if (SEG_VALID) begin
                        if (dec_ok) begin
                            WORD       <= {hi_nib, dec_nib};
                            WORD_VALID <= 1'b1;
                            state      <= FULL;
                        end else begin
                            // A bad low digit throws away the high nibble already held.
                            hi_nib    <= 4'h0;
                            state     <= EMPTY;
                            ERR       <= 1'b1;
                            ERR_TYPE  <= ERR_PATTERN;
                            ERR_COUNT <= sat_inc(ERR_COUNT);
                        end
                    end
`ifdef SEG7_READER_TIMEOUT_EN
                    // When the digit and the timeout land in the same cycle, the digit wins.
                    else if (idle_cnt == TO_LAST) begin
                        hi_nib    <= 4'h0;
                        state     <= EMPTY;
                        ERR       <= 1'b1;
                        ERR_TYPE  <= ERR_TIMEOUT;
                        ERR_COUNT <= sat_inc(ERR_COUNT);
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
`endif
                end
                FULL: begin
                    if (WORD_READY) begin
                        WORD_VALID <= 1'b0;
                        state      <= EMPTY;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    WORD_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule
